// File: rtl/cmoms_seq_pkg.sv
// Shared types and constants for the C-MOMS resampler rate/phase sequencer.
package cmoms_seq_pkg;

  localparam int CW          = 8;
  localparam int PW          = 2;
  localparam int PIPE_DEPTH  = 5;
  localparam int DEF_IN_PER  = 3;
  localparam int DEF_OUT_PER = 4;
  localparam int DEF_PHASES  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/cmoms_strobe_gen.sv
// Reloadable down-counter that emits a one-clock pulse every 'period' clocks
// while enabled; a period of 1 holds the pulse high continuously.
module cmoms_strobe_gen #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] period,
  output logic          pulse
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  // Reload happens at zero, so the counter never wraps through the top of its range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (load) begin
      cnt   <= period - ONE;
      pulse <= 1'b0;
    end else if (en) begin
      if (cnt == '0) begin
        cnt   <= period - ONE;
        pulse <= 1'b1;
      end else begin
        cnt   <= cnt - ONE;
        pulse <= 1'b0;
      end
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/cmoms_seq.sv
// Rate/phase sequencer: input/output strobes, LUT phase index and pipeline
// fill tracking for the C-MOMS datapath. 'reset' is asynchronous, active-low.
module cmoms_seq
  import cmoms_seq_pkg::*;
#(
  parameter int CW          = cmoms_seq_pkg::CW,
  parameter int PW          = cmoms_seq_pkg::PW,
  parameter int PIPE_DEPTH  = cmoms_seq_pkg::PIPE_DEPTH,
  parameter int DEF_IN_PER  = cmoms_seq_pkg::DEF_IN_PER,
  parameter int DEF_OUT_PER = cmoms_seq_pkg::DEF_OUT_PER,
  parameter int DEF_PHASES  = cmoms_seq_pkg::DEF_PHASES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_in_per,
  input  logic [CW-1:0] cfg_out_per,
  input  logic [PW-1:0] cfg_phases,
  input  logic          start,
  input  logic          stop,
  output logic          ena_in,
  output logic          ena_out,
  output logic [PW-1:0] phase,
  output logic          y_valid,
  output logic          busy,
  output logic          cfg_err
);

  localparam int DCW = $clog2(PIPE_DEPTH + 1);
  localparam logic [DCW-1:0] FILL_MAX   = DCW'(PIPE_DEPTH);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE_DEPTH - 1);
  localparam logic [DCW-1:0] D_ONE      = DCW'(1);
  localparam logic [PW-1:0]  P_ONE      = PW'(1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] in_per;
  logic [CW-1:0] out_per;
  logic [PW-1:0] phases;
  logic [DCW-1:0] fill;
  logic [DCW-1:0] drain_cnt;

  logic          cfg_valid;
  logic          cfg_accept;
  logic [CW-1:0] eff_in_per;
  logic [CW-1:0] eff_out_per;
  logic          load;
  logic          in_en;
  logic          out_en;
  logic          drain_last;

  // The upper phase bound 2**PW-1 is implied by the field width itself.
  assign cfg_valid  = (cfg_in_per != '0) && (cfg_out_per != '0) && (cfg_phases != '0);
  assign cfg_accept = cfg_we && (state == IDLE) && cfg_valid;

  // A write coinciding with start must already govern the first RUN period.
  assign eff_in_per  = cfg_accept ? cfg_in_per  : in_per;
  assign eff_out_per = cfg_accept ? cfg_out_per : out_per;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    in_en      = 1'b0;
    out_en     = 1'b0;
    drain_last = (state == DRAIN) && ena_out && (drain_cnt == DRAIN_LAST);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        out_en = 1'b1;
        if (stop) begin
          next_state = DRAIN;
        end else begin
          in_en = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          next_state = IDLE;
        end else begin
          out_en = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  cmoms_strobe_gen #(.CW(CW)) u_in_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (in_en),
    .load   (load),
    .period (eff_in_per),
    .pulse  (ena_in)
  );

  cmoms_strobe_gen #(.CW(CW)) u_out_gen (
    .clk    (clk),
    .reset  (reset),
    .en     (out_en),
    .load   (load),
    .period (eff_out_per),
    .pulse  (ena_out)
  );

  // Phase, fill and drain count all advance on the edge that closes an ena_out cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      in_per    <= CW'(DEF_IN_PER);
      out_per   <= CW'(DEF_OUT_PER);
      phases    <= PW'(DEF_PHASES);
      phase     <= '0;
      fill      <= '0;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if (cfg_we) begin
        if (cfg_accept) begin
          in_per  <= cfg_in_per;
          out_per <= cfg_out_per;
          phases  <= cfg_phases;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (load) begin
        phase     <= '0;
        fill      <= '0;
        drain_cnt <= '0;
      end else if (ena_out) begin
        phase <= (phase == phases - P_ONE) ? '0 : phase + P_ONE;
        if (fill != FILL_MAX) begin
          fill <= fill + D_ONE;
        end
        if (state == DRAIN) begin
          drain_cnt <= drain_cnt + D_ONE;
        end
      end
    end
  end

  // Fill saturates at PIPE_DEPTH, so equality is the ">= PIPE_DEPTH" test.
  assign y_valid = ena_out && (fill == FILL_MAX);

  a_ena_in_only_in_run : assert property (@(posedge clk) disable iff (!reset)
    ena_in |-> (state == RUN));
  a_busy_tracks_state : assert property (@(posedge clk) disable iff (!reset)
    busy == (state != IDLE));
  a_phase_in_range : assert property (@(posedge clk) disable iff (!reset)
    ena_out |-> (phase < phases));

endmodule

// File: tb/tb_cmoms_seq.sv
// Scoreboard bench for cmoms_seq: expected strobe events come from a cadence
// model and are matched by a monitor whenever the DUT strobes.
module tb_cmoms_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_in_per;
  logic [7:0] cfg_out_per;
  logic [1:0] cfg_phases;
  logic       start;
  logic       stop;
  logic       ena_in;
  logic       ena_out;
  logic [1:0] phase;
  logic       y_valid;
  logic       busy;
  logic       cfg_err;

  typedef struct {
    int t;
    int ph;
    int yv;
  } out_ev_t;

  out_ev_t out_q[$];
  int      in_q[$];

  int cyc   = 0;
  int t0    = 0;
  int n_cmp = 0;
  int n_err = 0;

  int m_in  = 3;
  int m_out = 4;
  int m_ph  = 3;
  int m_err = 0;

  cmoms_seq dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_in_per  (cfg_in_per),
    .cfg_out_per (cfg_out_per),
    .cfg_phases  (cfg_phases),
    .start       (start),
    .stop        (stop),
    .ena_in      (ena_in),
    .ena_out     (ena_out),
    .phase       (phase),
    .y_valid     (y_valid),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d after start)", name, act, exp, cyc - t0);
    end
  endtask

  function automatic void model_cfg(input int ip, input int op, input int ph, input bit idle);
    if (idle && ip >= 1 && op >= 1 && ph >= 1 && ph <= 3) begin
      m_in  = ip;
      m_out = op;
      m_ph  = ph;
      m_err = 0;
    end else begin
      m_err = 1;
    end
  endfunction

  // Monitor: pop one expectation per strobe seen on the falling edge.
  always @(negedge clk) begin : monitor
    out_ev_t ev;
    int      et;
    if (reset === 1'b1) begin
      if (ena_out === 1'b1) begin
        if (out_q.size() == 0) begin
          check_output("unexpected ena_out", cyc - t0, -1);
        end else begin
          ev = out_q.pop_front();
          check_output("ena_out time", cyc - t0, ev.t);
          check_output("phase", int'(phase), ev.ph);
          check_output("y_valid", int'(y_valid), ev.yv);
        end
      end else begin
        check_output("y_valid without ena_out", int'(y_valid), 0);
      end
      if (ena_in === 1'b1) begin
        if (in_q.size() == 0) begin
          check_output("unexpected ena_in", cyc - t0, -1);
        end else begin
          et = in_q.pop_front();
          check_output("ena_in time", cyc - t0, et);
        end
      end
    end
  end

  task automatic write_cfg(input int ip, input int op, input int ph);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_in_per  = 8'(ip);
    cfg_out_per = 8'(op);
    cfg_phases  = 2'(ph);
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(ip, op, ph, 1'b1);
    check_output("cfg_err after write", int'(cfg_err), m_err);
  endtask

  // One start..stop..drain run: ena_in k*in_per up to the stop cycle,
  // ena_out k*out_per for n_run+PIPE_DEPTH pulses, y_valid from pulse 6.
  task automatic apply_stimulus(input bit with_cfg, input int ip, input int op, input int ph,
                                input int n_run, input bit cfg_mid, input bit abort);
    int s;
    int t_end;
    int t_abort;
    if (with_cfg) model_cfg(ip, op, ph, 1'b1);
    s       = n_run * m_out;
    t_end   = (n_run + 5) * m_out;
    t_abort = s + 3;
    for (int t = m_in; t <= s; t += m_in) in_q.push_back(t);
    for (int k = 1; k <= n_run + 5; k++)
      out_q.push_back('{t: k * m_out, ph: (k - 1) % m_ph, yv: (k > 5) ? 1 : 0});

    @(negedge clk);
    start = 1'b1;
    if (with_cfg) begin
      cfg_we      = 1'b1;
      cfg_in_per  = 8'(ip);
      cfg_out_per = 8'(op);
      cfg_phases  = 2'(ph);
    end
    @(posedge clk);
    #1;
    t0     = cyc;
    start  = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk);
    check_output("busy after start", int'(busy), 1);
    if (with_cfg) check_output("cfg_err at start", int'(cfg_err), m_err);

    if (cfg_mid) begin
      while (cyc - t0 < s / 2) @(negedge clk);
      cfg_we      = 1'b1;
      cfg_in_per  = 8'd1;
      cfg_out_per = 8'd1;
      cfg_phases  = 2'd1;
      @(negedge clk);
      cfg_we = 1'b0;
      m_err  = 1;
      check_output("cfg_err write in RUN", int'(cfg_err), 1);
    end

    while (cyc - t0 < s) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    if (abort) begin
      while (cyc - t0 < t_abort) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_output("outputs during async reset",
                   int'({ena_in, ena_out, y_valid, busy, cfg_err, phase}), 0);
      out_q.delete();
      in_q.delete();
      m_in  = 3;
      m_out = 4;
      m_ph  = 3;
      m_err = 0;
      @(negedge clk);
      reset = 1'b1;
    end else begin
      while (cyc - t0 < t_end) @(negedge clk);
      check_output("busy on last ena_out", int'(busy), 1);
      @(negedge clk);
      check_output("busy after drain", int'(busy), 0);
      check_output("ena_out events left", out_q.size(), 0);
      check_output("ena_in events left", in_q.size(), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  ip;
    int  op;
    int  ph;
    int  n;
    int  wc;
    reset       = 1'b0;
    cfg_we      = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    cfg_in_per  = 8'd0;
    cfg_out_per = 8'd0;
    cfg_phases  = 2'd0;
    #12;
    check_output("outputs in reset", int'({ena_in, ena_out, y_valid, busy, cfg_err, phase}), 0);
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus(1'b0, 0, 0, 0, 7, 1'b0, 1'b0);

    write_cfg(3, 0, 3);
    apply_stimulus(1'b0, 0, 0, 0, 4, 1'b0, 1'b0);

    write_cfg(2, 5, 2);
    apply_stimulus(1'b0, 0, 0, 0, 6, 1'b0, 1'b0);

    apply_stimulus(1'b0, 0, 0, 0, 8, 1'b1, 1'b0);

    apply_stimulus(1'b0, 0, 0, 0, 7, 1'b1, 1'b1);
    apply_stimulus(1'b0, 0, 0, 0, 7, 1'b0, 1'b0);

    apply_stimulus(1'b1, 1, 1, 1, 8, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ip = int'($urandom_range(0, 5));
      op = int'($urandom_range(0, 6));
      ph = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 9));
      wc = int'($urandom_range(0, 1));
      if (wc == 1) begin
        apply_stimulus(1'b1, ip, op, ph, n, 1'b0, 1'b0);
      end else begin
        write_cfg(ip, op, ph);
        apply_stimulus(1'b0, 0, 0, 0, n, 1'b0, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
